// File: rtl/proc_bench_pkg.sv
// proc_bench_pkg
//   Shared types for the processor run controller / writeback tracer.
//   - state_t       : controller phase (HOLD -> RUN -> STOP)
//   - trace_entry_t : trace record layout {addr, data, cycle} at the default
//                     widths; the controller declares the same layout at its
//                     own parameter widths and hands it to the FIFO as a type.
package proc_bench_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int unsigned TRACE_ADDR_W = 3;
    localparam int unsigned TRACE_DATA_W = 16;
    localparam int unsigned TRACE_CYC_W  = 10;

    typedef struct packed {
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] data;
        logic [TRACE_CYC_W-1:0]  cycle;
    } trace_entry_t;

endpackage

// File: rtl/proc_bench_ctrl_if.sv
// proc_bench_ctrl_if
//   Trace drain port (valid/ready) between the controller and a host.
//   master : controller side, drives the head entry and trace_valid
//   slave  : host side, drives trace_ready
//   Signals: trace_valid, trace_ready, trace_addr[ADDR_W], trace_data[DATA_W],
//            trace_cycle[CYC_W]
interface proc_bench_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned CYC_W  = 10
);
    logic              trace_valid;
    logic              trace_ready;
    logic [ADDR_W-1:0] trace_addr;
    logic [DATA_W-1:0] trace_data;
    logic [CYC_W-1:0]  trace_cycle;

    modport master (
        output trace_valid,
        output trace_addr,
        output trace_data,
        output trace_cycle,
        input  trace_ready
    );

    modport slave (
        input  trace_valid,
        input  trace_addr,
        input  trace_data,
        input  trace_cycle,
        output trace_ready
    );
endinterface

// File: rtl/proc_bench_ctrl_trace_fifo.sv
// trace_fifo
//   Synchronous first-word-fall-through FIFO of DEPTH entries of type entry_t.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset (clears pointers)
//     push_i       : write push_data_i; accepted when not full or when popping
//     push_data_i  : entry to write
//     pop_i        : consume head entry (ignored when empty)
//     head_o       : current head entry (stale contents when empty)
//     full_o       : DEPTH entries held
//     empty_o      : no entries held
import proc_bench_pkg::*;

module trace_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter type         entry_t = trace_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/proc_bench_ctrl.sv
// proc_bench_ctrl
//   Run controller and writeback tracer for the pipelined processor.
//   Holds the core in reset for RST_CYCLES cycles, then runs it while counting
//   cycles and capturing every register writeback into a cycle-stamped trace
//   FIFO. The run stops on a halt (PC unchanged for HALT_CYCLES consecutive
//   samples) or on timeout; the FIFO stays drainable afterwards.
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     pc_in             : processor PC
//     wb_en/addr/data   : processor register writeback stream
//     proc_reset        : reset to the processor core (active-high)
//     trace             : trace drain port (proc_bench_ctrl_if.master)
//     cycle_count       : RUN cycles elapsed
//     overflow          : sticky, a writeback was dropped on a full FIFO
//     done / timeout    : sticky halt / timeout flags
//     mirror_sel/data   : shadow register file read port
//   Macro PROC_BENCH_REGMIRROR_EN: when defined, adds a shadow register file fed
//   by the writeback stream in RUN; otherwise mirror_data is 0 and mirror_sel is
//   ignored.
import proc_bench_pkg::*;

module proc_bench_ctrl #(
    parameter  int unsigned DATA_W      = 16,
    parameter  int unsigned ADDR_W      = 3,
    parameter  int unsigned DEPTH       = 16,
    parameter  int unsigned RST_CYCLES  = 2,
    parameter  int unsigned TIMEOUT     = 1000,
    parameter  int unsigned HALT_CYCLES = 4,
    localparam int unsigned CYC_W       = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    pc_in,
    input  logic                 wb_en,
    input  logic [ADDR_W-1:0]    wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 proc_reset,
    proc_bench_ctrl_if.master    trace,
    output logic [CYC_W-1:0]     cycle_count,
    output logic                 overflow,
    output logic                 done,
    output logic                 timeout,
    input  logic [ADDR_W-1:0]    mirror_sel,
    output logic [DATA_W-1:0]    mirror_data
);
    localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int unsigned STAB_W = $clog2(HALT_CYCLES + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [CYC_W-1:0]  cycle;
    } entry_t;

    state_t              state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [CYC_W-1:0]    cycle_q;
    logic [DATA_W-1:0]   pc_prev_q;
    logic                pc_prev_vld_q;
    logic [STAB_W-1:0]   stable_q;
    logic [STAB_W-1:0]   stable_d;
    logic                proc_reset_q;
    logic                overflow_q;
    logic                done_q;
    logic                timeout_q;

    logic                in_run;
    logic                capture;
    logic                pop;
    logic                pc_same;
    logic                halt_hit;
    logic                tmo_hit;
    logic                fifo_full;
    logic                fifo_empty;
    entry_t              fifo_head;
    entry_t              push_entry;

    assign in_run     = (state_q == RUN);
    assign capture    = in_run && wb_en;
    assign pop        = !fifo_empty && trace.trace_ready;
    assign push_entry = '{addr: wb_addr, data: wb_data, cycle: cycle_q};

    // The first RUN cycle has no valid previous PC, so it always counts as a change.
    assign pc_same  = pc_prev_vld_q && (pc_in == pc_prev_q);
    assign stable_d = pc_same ? stable_q + 1'b1 : '0;
    assign halt_hit = in_run && (stable_d == STAB_W'(HALT_CYCLES));
    assign tmo_hit  = in_run && (cycle_q == CYC_W'(TIMEOUT - 1));

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (capture),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HOLD;
            hold_q        <= '0;
            cycle_q       <= '0;
            pc_prev_q     <= '0;
            pc_prev_vld_q <= 1'b0;
            stable_q      <= '0;
            proc_reset_q  <= 1'b1;
            overflow_q    <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    // Counts RST_CYCLES edges, then releases on the following one.
                    if (hold_q == HOLD_W'(RST_CYCLES)) begin
                        state_q      <= RUN;
                        proc_reset_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                RUN: begin
                    pc_prev_q     <= pc_in;
                    pc_prev_vld_q <= 1'b1;
                    stable_q      <= stable_d;
                    if (capture && fifo_full && !pop) begin
                        overflow_q <= 1'b1;
                    end
                    if (halt_hit) begin
                        done_q <= 1'b1;
                    end
                    if (tmo_hit) begin
                        timeout_q <= 1'b1;
                    end
                    // The count freezes at the value of the last RUN cycle.
                    if (halt_hit || tmo_hit) begin
                        state_q      <= STOP;
                        proc_reset_q <= 1'b1;
                    end else begin
                        cycle_q <= cycle_q + 1'b1;
                    end
                end
                STOP: begin
                    proc_reset_q <= 1'b1;
                end
                default: begin
                    state_q      <= HOLD;
                    proc_reset_q <= 1'b1;
                end
            endcase
        end
    end

    assign proc_reset        = proc_reset_q;
    assign cycle_count       = cycle_q;
    assign overflow          = overflow_q;
    assign done              = done_q;
    assign timeout           = timeout_q;

    assign trace.trace_valid = !fifo_empty;
    assign trace.trace_addr  = fifo_empty ? '0 : fifo_head.addr;
    assign trace.trace_data  = fifo_empty ? '0 : fifo_head.data;
    assign trace.trace_cycle = fifo_empty ? '0 : fifo_head.cycle;

`ifdef PROC_BENCH_REGMIRROR_EN
    logic [DATA_W-1:0] mirror_q [2**ADDR_W];

    // Written from the writeback stream regardless of FIFO occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            mirror_q <= '{default: '0};
        end else if (capture) begin
            mirror_q[wb_addr] <= wb_data;
        end
    end

    assign mirror_data = mirror_q[mirror_sel];
`else
    logic unused_mirror_sel;
    assign unused_mirror_sel = ^mirror_sel;
    assign mirror_data       = '0;
`endif
endmodule

// File: tb/tb_proc_bench_ctrl.sv
module tb_proc_bench_ctrl;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 3;
    localparam int DEPTH       = 4;
    localparam int RST_CYCLES  = 2;
    localparam int TIMEOUT     = 50;
    localparam int HALT_CYCLES = 4;
    localparam int CYC_W       = $clog2(TIMEOUT + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] pc_in;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              proc_reset;
    logic [CYC_W-1:0]  cycle_count;
    logic              overflow;
    logic              done;
    logic              timeout;
    logic [ADDR_W-1:0] mirror_sel;
    logic [DATA_W-1:0] mirror_data;

    always #5 clk = ~clk;

    proc_bench_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W)) tif ();

    proc_bench_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .RST_CYCLES  (RST_CYCLES),
        .TIMEOUT     (TIMEOUT),
        .HALT_CYCLES (HALT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .proc_reset  (proc_reset),
        .trace       (tif),
        .cycle_count (cycle_count),
        .overflow    (overflow),
        .done        (done),
        .timeout     (timeout),
        .mirror_sel  (mirror_sel),
        .mirror_data (mirror_data)
    );

    int n_pass  = 0;
    int n_total = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int addr;
        int data;
        int cyc;
    } ent_t;

    ent_t mq[$];
    int   pc_hist[$];
    int   m_mode  = 0;  // 0: core held, 1: running, 2: stopped
    int   m_hold  = 0;
    int   m_cc    = 0;
    bit   m_ovf   = 0;
    bit   m_done  = 0;
    bit   m_to    = 0;
    int   m_mirror[8];
    bit   mcheck  = 0;

    task automatic model_edge();
        bit halt;
        bit to;
        if (reset) begin
            mq.delete();
            pc_hist.delete();
            m_mode = 0; m_hold = 0; m_cc = 0;
            m_ovf = 0; m_done = 0; m_to = 0;
            foreach (m_mirror[i]) m_mirror[i] = 0;
        end else begin
            if (mq.size() > 0 && tif.trace_ready) void'(mq.pop_front());
            case (m_mode)
                0: begin
                    m_hold++;
                    if (m_hold > RST_CYCLES) m_mode = 1;
                end
                1: begin
                    if (wb_en) begin
                        if (mq.size() < DEPTH) mq.push_back('{int'(wb_addr), int'(wb_data), m_cc});
                        else m_ovf = 1;
                        m_mirror[wb_addr] = int'(wb_data);
                    end
                    pc_hist.push_back(int'(pc_in));
                    if (pc_hist.size() > HALT_CYCLES + 1) void'(pc_hist.pop_front());
                    halt = (pc_hist.size() == HALT_CYCLES + 1);
                    for (int i = 1; i < pc_hist.size(); i++)
                        if (pc_hist[i] != pc_hist[0]) halt = 0;
                    to = (m_cc == TIMEOUT - 1);
                    if (halt) m_done = 1;
                    if (to) m_to = 1;
                    if (halt || to) m_mode = 2;
                    else m_cc++;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        int exp_mirror;
        chk("m_proc_reset", proc_reset, (m_mode != 1));
        chk("m_valid", tif.trace_valid, (mq.size() > 0));
        chk("m_addr", tif.trace_addr, (mq.size() > 0) ? mq[0].addr : 0);
        chk("m_data", tif.trace_data, (mq.size() > 0) ? mq[0].data : 0);
        chk("m_tcycle", tif.trace_cycle, (mq.size() > 0) ? mq[0].cyc : 0);
        chk("m_cycle_count", cycle_count, m_cc);
        chk("m_overflow", overflow, m_ovf);
        chk("m_done", done, m_done);
        chk("m_timeout", timeout, m_to);
`ifdef PROC_BENCH_REGMIRROR_EN
        exp_mirror = m_mirror[mirror_sel];
`else
        exp_mirror = 0;
`endif
        chk("m_mirror", mirror_data, exp_mirror);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        if (mcheck) check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wb_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10 && proc_reset; i++) tick();
        chk("release", proc_reset, 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit rst; bit we; int wa; int wd; int pc; bit rdy;
        bit e_pr; bit e_v; int e_a; int e_d; int e_c; int e_cc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pc_in = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        mirror_sel = '0; tif.trace_ready = 1'b1;

        tbl[0]  = '{1, 0, 0, 0,      'h100, 1,  1, 0, 0, 0,      0, 0};
        tbl[1]  = '{1, 0, 0, 0,      'h104, 1,  1, 0, 0, 0,      0, 0};
        tbl[2]  = '{0, 0, 0, 0,      'h108, 1,  1, 0, 0, 0,      0, 0};
        tbl[3]  = '{0, 0, 0, 0,      'h10C, 1,  1, 0, 0, 0,      0, 0};
        tbl[4]  = '{0, 0, 0, 0,      'h110, 1,  0, 0, 0, 0,      0, 0};
        tbl[5]  = '{0, 0, 0, 0,      'h114, 1,  0, 0, 0, 0,      0, 1};
        tbl[6]  = '{0, 0, 0, 0,      'h118, 1,  0, 0, 0, 0,      0, 2};
        tbl[7]  = '{0, 0, 0, 0,      'h11C, 1,  0, 0, 0, 0,      0, 3};
        tbl[8]  = '{0, 0, 0, 0,      'h120, 1,  0, 0, 0, 0,      0, 4};
        tbl[9]  = '{0, 0, 0, 0,      'h124, 1,  0, 0, 0, 0,      0, 5};
        tbl[10] = '{0, 1, 3, 'h00A5, 'h128, 1,  0, 1, 3, 'h00A5, 5, 6};
        tbl[11] = '{0, 0, 0, 0,      'h12C, 1,  0, 0, 0, 0,      0, 7};
        tbl[12] = '{0, 0, 0, 0,      'h130, 1,  0, 0, 0, 0,      0, 8};
        tbl[13] = '{0, 0, 0, 0,      'h134, 1,  0, 0, 0, 0,      0, 9};
        tbl[14] = '{0, 1, 7, 'hFFFF, 'h138, 1,  0, 1, 7, 'hFFFF, 9, 10};
        tbl[15] = '{0, 0, 0, 0,      'h13C, 1,  0, 0, 0, 0,      0, 11};

        foreach (tbl[i]) begin
            reset = tbl[i].rst; wb_en = tbl[i].we;
            wb_addr = ADDR_W'(tbl[i].wa); wb_data = DATA_W'(tbl[i].wd);
            pc_in = DATA_W'(tbl[i].pc); tif.trace_ready = tbl[i].rdy;
            tick();
            chk("t_proc_reset", proc_reset, tbl[i].e_pr);
            chk("t_valid", tif.trace_valid, tbl[i].e_v);
            chk("t_addr", tif.trace_addr, tbl[i].e_a);
            chk("t_data", tif.trace_data, tbl[i].e_d);
            chk("t_tcycle", tif.trace_cycle, tbl[i].e_c);
            chk("t_cycle_count", cycle_count, tbl[i].e_cc);
        end
        wb_en = 1'b0;

        // Overflow: 6 writebacks into a 4-deep FIFO, then drain.
        tif.trace_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wb_en = 1'b1; wb_addr = ADDR_W'(i); wb_data = DATA_W'('h1000 + i);
            pc_in = DATA_W'('h200 + i);
            tick();
        end
        wb_en = 1'b0;
        chk("ovf_flag", overflow, 1);
        chk("ovf_valid", tif.trace_valid, 1);
        tif.trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", tif.trace_addr, i);
            chk("drain_data", tif.trace_data, 'h1000 + i);
            chk("drain_cycle", tif.trace_cycle, i);
            pc_in = DATA_W'('h300 + i);
            tick();
        end
        chk("drain_empty", tif.trace_valid, 0);
        chk("drain_ovf_sticky", overflow, 1);

        // Halt: PC climbs to 0x20 and sticks.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            pc_in = DATA_W'('h10 + 2 * k);
            tick();
        end
        pc_in = 'h20;
        for (int k = 0; k < 4; k++) tick();
        chk("halt_not_yet", done, 0);
        tick();
        chk("halt_done", done, 1);
        chk("halt_proc_reset", proc_reset, 1);
        chk("halt_cycle_count", cycle_count, 12);
        for (int k = 0; k < 3; k++) begin
            pc_in = DATA_W'('h30 + k);
            tick();
        end
        chk("halt_frozen", cycle_count, 12);
        chk("halt_stays", done, 1);
        chk("halt_no_timeout", timeout, 0);
        chk("halt_still_stop", proc_reset, 1);

        // Timeout: PC never stable.
        do_reset();
        for (int k = 0; k < 49; k++) begin
            pc_in = DATA_W'(3 * k);
            tick();
        end
        chk("tmo_before", timeout, 0);
        chk("tmo_cc_before", cycle_count, 49);
        pc_in = 'h3FF;
        tick();
        chk("tmo_flag", timeout, 1);
        chk("tmo_cycle_count", cycle_count, 49);
        chk("tmo_done", done, 0);
        chk("tmo_proc_reset", proc_reset, 1);

        // Reset mid-run with 3 queued entries and overflow set.
        tif.trace_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wb_en = 1'b1; wb_addr = ADDR_W'(i + 1); wb_data = DATA_W'('hBEE0 + i);
            pc_in = DATA_W'('h400 + i);
            tick();
        end
        wb_en = 1'b0;
        tif.trace_ready = 1'b1;
        pc_in = 'h500;
        tick();
        tif.trace_ready = 1'b0;
        chk("mid_valid_before", tif.trace_valid, 1);
        chk("mid_ovf_before", overflow, 1);
        reset = 1'b1;
        tick();
        chk("mid_valid", tif.trace_valid, 0);
        chk("mid_addr", tif.trace_addr, 0);
        chk("mid_data", tif.trace_data, 0);
        chk("mid_overflow", overflow, 0);
        chk("mid_done", done, 0);
        chk("mid_timeout", timeout, 0);
        chk("mid_proc_reset", proc_reset, 1);
        chk("mid_cycle_count", cycle_count, 0);
        for (int s = 0; s < (1 << ADDR_W); s++) begin
            mirror_sel = ADDR_W'(s);
            #1;
            chk("mid_mirror", mirror_data, 0);
        end
        reset = 1'b0;

        // Randomized runs against the reference model.
        mcheck = 1'b1;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                reset           = ($urandom_range(0, 99) == 0);
                wb_en           = $urandom_range(0, 1);
                wb_addr         = ADDR_W'($urandom);
                wb_data         = DATA_W'($urandom);
                tif.trace_ready = (r % 3 == 0) ? ($urandom_range(0, 3) == 0)
                                               : ($urandom_range(0, 2) != 0);
                mirror_sel      = ADDR_W'($urandom);
                if ((r % 2 == 0) || ($urandom_range(0, 3) == 0))
                    pc_in = DATA_W'($urandom);
                tick();
            end
            reset = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
